// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// This block shares the single write port of the team FIFO among N_REQ
// producers. It arbitrates between them in round-robin order. It also owns
// the FIFO read strobe: it forwards consumer reads in normal operation and
// discards the FIFO contents when a flush is requested.
//
// Optional build macro: FIFO_WR_ARBITER_STATS_EN
//   When this macro is defined, the block adds the grant_count output. That
//   output holds one saturating 16-bit accepted-transfer counter per
//   requester.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_data_in,
  input  logic                   cons_read,
  output logic                   fifo_read,
  input  logic                   flush_req,
  output logic                   flush_done
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    grant_count
`endif
);

  // The rotating scan sum is one bit wider than the pointer, so that
  // rr_ptr + k cannot overflow before the modulo fold.
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] rrPtr_q;
  logic [PTR_W-1:0] rrPtr_d;
  logic             flushDone_q;

  logic             winFound;
  logic [PTR_W-1:0] winIdx;
  logic [SUM_W-1:0] scanSum;
  logic             grantFire;

  // Find the first valid requester, scanning upward from rr_ptr and wrapping modulo N_REQ.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    scanSum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scanSum = {1'b0, rrPtr_q} + SUM_W'(k);
      if (scanSum >= SUM_W'(N_REQ)) begin
        scanSum = scanSum - SUM_W'(N_REQ);
      end
      if (!winFound && req_valid[scanSum[PTR_W-1:0]]) begin
        winFound = 1'b1;
        winIdx   = scanSum[PTR_W-1:0];
      end
    end
  end

  // A transfer happens only in ARB, without a flush request, with a winner and FIFO space.
  always_comb begin
    grantFire = (state_q == ARB) && !flush_req && winFound && !fifo_full;
  end

  // The pointer moves to the index just after the winner, so the winner goes last next round.
  always_comb begin
    if (winIdx == PTR_W'(N_REQ - 1)) begin
      rrPtr_d = '0;
    end else begin
      rrPtr_d = winIdx + PTR_W'(1);
    end
  end

  // Strobes and write data are combinational for zero latency; reset forces every strobe low.
  always_comb begin
    req_ready    = '0;
    fifo_write   = 1'b0;
    fifo_data_in = '0;
    fifo_read    = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (!flush_req) begin
            if (grantFire) begin
              req_ready[winIdx] = 1'b1;
              fifo_write        = 1'b1;
              fifo_data_in      = req_data[int'(winIdx)*WIDTH +: WIDTH];
            end
            fifo_read = cons_read & ~fifo_empty;
          end
        end
        DRAIN: begin
          fifo_read = ~fifo_empty;
        end
        default: begin
        end
      endcase
    end
  end

  // Control FSM: it handles arbitration, the flush drain, and a one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rrPtr_q     <= '0;
      flushDone_q <= 1'b0;
    end else begin
      flushDone_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (flush_req) begin
            state_q <= DRAIN;
          end else if (grantFire) begin
            rrPtr_q <= rrPtr_d;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_q     <= DONE;
            flushDone_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= ARB;
          rrPtr_q <= '0;
        end
        default: begin
          state_q <= ARB;
        end
      endcase
    end
  end

  assign flush_done = flushDone_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N_REQ*16-1:0] grantCnt_q;

  // Per-requester accepted-transfer counters: they saturate at all-ones and only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      grantCnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grantCnt_q[i*16 +: 16] != 16'hFFFF)) begin
          grantCnt_q[i*16 +: 16] <= grantCnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_count = grantCnt_q;
`endif

endmodule
